// File: rtl/fifo_umbrales_pkg.sv
// fifo_umbrales_pkg: shared FIFO geometry defaults and status bundle for the port buffers, arbiter and benches.
package fifo_umbrales_pkg;

    localparam int FU_DATA_WIDTH = 10;
    localparam int FU_ADDR_WIDTH = 3;
    localparam int FU_DEPTH      = 2 ** FU_ADDR_WIDTH;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/fifo_umbrales.sv
// fifo_umbrales: per-port synchronous FIFO with registered read data, occupancy thresholds
// and sticky overflow/underflow flags.
module fifo_umbrales
    import fifo_umbrales_pkg::*;
#(
    parameter int DATA_WIDTH = FU_DATA_WIDTH,
    parameter int ADDR_WIDTH = FU_ADDR_WIDTH,
    parameter int DEPTH      = FU_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH:0]   umbral_alto,
    input  logic [ADDR_WIDTH:0]   umbral_bajo,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error_push,
    output logic                  error_pop
);

    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  push_ok;
    logic                  pop_ok;
    fifo_status_t          st;

    // Flags depend on registered occupancy and live thresholds only.
    always_comb begin
        st.full         = count == CNT_FULL;
        st.empty        = count == '0;
        st.almost_full  = count >= umbral_alto;
        st.almost_empty = count <= umbral_bajo;
    end

    assign full         = st.full;
    assign empty        = st.empty;
    assign almost_full  = st.almost_full;
    assign almost_empty = st.almost_empty;

    // A pop on full frees the slot the same-cycle push lands in.
    assign pop_ok  = pop & ~st.empty;
    assign push_ok = push & (~st.full | pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out   <= '0;
            error_push <= 1'b0;
            error_pop  <= 1'b0;
        end else begin
            wr_ptr     <= push_ok ? wr_ptr + PTR_ONE : wr_ptr;
            rd_ptr     <= pop_ok ? rd_ptr + PTR_ONE : rd_ptr;
            count      <= count + (push_ok ? CNT_ONE : '0) - (pop_ok ? CNT_ONE : '0);
            data_out   <= pop_ok ? mem[rd_ptr] : data_out;
            error_push <= error_push | (push & ~push_ok);
            error_pop  <= error_pop | (pop & ~pop_ok);
        end
    end

endmodule

// File: tb/tb_fifo_umbrales.sv
// tb_fifo_umbrales: directed bench with a queue-based reference model checked every cycle.
module tb_fifo_umbrales;
    import fifo_umbrales_pkg::*;

    localparam int DW = FU_DATA_WIDTH;
    localparam int AW = FU_ADDR_WIDTH;
    localparam int DP = FU_DEPTH;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic          pop;
    logic [DW-1:0] data_in;
    logic [AW:0]   umbral_alto;
    logic [AW:0]   umbral_bajo;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          error_push;
    logic          error_pop;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_epush;
    logic          m_epop;

    fifo_umbrales dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
        .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo), .data_out(data_out),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .error_push(error_push), .error_pop(error_pop)
    );

    always #5 clk = ~clk;

    // Reference: a plain queue; pop takes the head, push appends if room remains after the pop.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_dout  = '0;
            m_epush = 1'b0;
            m_epop  = 1'b0;
        end else begin
            bit pok;
            bit wok;
            pok = pop && q.size() > 0;
            wok = push && (q.size() < DP || pok);
            if (pok) m_dout = q.pop_front();
            if (wok) q.push_back(data_in);
            if (pop && !pok) m_epop = 1'b1;
            if (push && !wok) m_epush = 1'b1;
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("m_data_out", data_out, m_dout);
        check("m_full", DW'(full), DW'(q.size() == DP));
        check("m_empty", DW'(empty), DW'(q.size() == 0));
        check("m_almost_full", DW'(almost_full), DW'(q.size() >= int'(umbral_alto)));
        check("m_almost_empty", DW'(almost_empty), DW'(q.size() <= int'(umbral_bajo)));
        check("m_error_push", DW'(error_push), DW'(m_epush));
        check("m_error_pop", DW'(error_pop), DW'(m_epop));
    end

    task automatic cyc(input logic pu, input logic po, input logic [DW-1:0] d);
        push = pu;
        pop = po;
        data_in = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop = 1'b0;
    endtask

    logic [DW-1:0] w [8] = '{10'h011, 10'h022, 10'h033, 10'h044, 10'h055, 10'h066, 10'h077, 10'h088};

    initial begin
        reset = 1'b1;
        push = 1'b0;
        pop = 1'b0;
        data_in = '0;
        umbral_alto = 4'd6;
        umbral_bajo = 4'd1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", DW'(empty), 10'd1);
        check("rst_almost_empty", DW'(almost_empty), 10'd1);
        check("rst_full", DW'(full), 10'd0);
        check("rst_data_out", data_out, 10'h000);
        check("rst_errors", DW'({error_push, error_pop}), 10'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        cyc(1, 0, 10'h3A1);
        cyc(1, 0, 10'h002);
        cyc(1, 0, 10'h1FF);
        cyc(0, 1, '0);
        check("pop1", data_out, 10'h3A1);
        cyc(0, 1, '0);
        check("pop2", data_out, 10'h002);
        cyc(0, 1, '0);
        check("pop3", data_out, 10'h1FF);
        check("pop3_empty", DW'(empty), 10'd1);

        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, w[i]);
            if (i == 4) check("af_at5", DW'(almost_full), 10'd0);
            if (i == 5) check("af_at6", DW'(almost_full), 10'd1);
            if (i == 6) check("full_at7", DW'(full), 10'd0);
        end
        check("full_at8", DW'(full), 10'd1);
        cyc(1, 0, 10'h3FF);
        check("overflow_err", DW'(error_push), 10'd1);
        check("overflow_full", DW'(full), 10'd1);

        cyc(1, 1, 10'h155);
        check("full_pp_head", data_out, 10'h011);
        check("full_pp_full", DW'(full), 10'd1);
        for (int i = 1; i < 8; i++) cyc(0, 1, '0);
        check("drain_w7", data_out, 10'h088);
        cyc(0, 1, '0);
        check("drain_155", data_out, 10'h155);
        check("drain_empty", DW'(empty), 10'd1);

        check("no_uflow_yet", DW'(error_pop), 10'd0);
        cyc(0, 1, '0);
        check("uflow_err", DW'(error_pop), 10'd1);
        check("uflow_dout", data_out, 10'h155);
        cyc(1, 1, 10'h0AB);
        check("pp_empty_dout", data_out, 10'h155);
        check("pp_empty_occ1", DW'({empty, almost_empty}), 10'b01);
        cyc(0, 1, '0);
        check("pp_empty_word", data_out, 10'h0AB);

        cyc(1, 0, 10'h101);
        cyc(1, 0, 10'h102);
        cyc(1, 0, 10'h103);
        umbral_alto = 4'd3;
        umbral_bajo = 4'd3;
        #1;
        check("thr_af3", DW'(almost_full), 10'd1);
        check("thr_ae3", DW'(almost_empty), 10'd1);
        umbral_alto = 4'd4;
        umbral_bajo = 4'd2;
        #1;
        check("thr_af4", DW'({almost_full, almost_empty}), 10'b00);
        umbral_alto = 4'd6;
        umbral_bajo = 4'd1;

        cyc(1, 0, 10'h104);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_empty", DW'(empty), 10'd1);
        check("midrst_dout", data_out, 10'h000);
        check("midrst_err", DW'({error_push, error_pop, full}), 10'd0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc(1, 0, 10'h2AA);
        cyc(0, 1, '0);
        check("post_rst_word", data_out, 10'h2AA);
        check("post_rst_empty", DW'(empty), 10'd1);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
